seg_disp: RTL



---
 rtl/seg_disp.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg_disp.sv
// Multi-digit seven-segment controller: hex capture or iterative double-dabble decimal,
// with leading-zero blanking, decimal points, blinking and overflow dashes.
module seg_disp #(
  parameter int DIGITS    = 8,
  parameter int W         = 32,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_value,
  input  logic                  in_dec,
  input  logic                  in_lzb,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [8*DIGITS-1:0]   o_seg,
  output logic                  o_ovf
);
  localparam int NB   = (W + 2) / 3;
  localparam int BCDW = 4 * NB;
  localparam int NP   = (NB > DIGITS) ? NB : DIGITS;
  localparam int BP   = 4 * NP;
  localparam int VP   = (W > 4 * DIGITS) ? W : 4 * DIGITS;
  localparam int CW   = $clog2(W + 1);
  localparam int BW   = $clog2(BLINK_DIV);

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      dig_reg [DIGITS];
  logic [3:0]      dig_next [DIGITS];
  logic            ovf_reg, ovf_next;
  logic            lzb_reg, lzb_next;
  logic            lzb_pend_reg, lzb_pend_next;
  logic [BCDW-1:0] bcd_reg, bcd_next;
  logic [W-1:0]    sh_reg, sh_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [BW-1:0]   blink_cnt_reg;
  logic            phase_reg;

  logic [BCDW-1:0] bcd_adj;
  logic [BCDW-1:0] bcd_shift;
  logic [BP-1:0]   bcd_pad;
  logic [VP-1:0]   val_pad;
  logic            hex_ovf, dec_ovf;

  // Add-3 correction on every BCD digit that would reach 10 or more after the shift
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                                 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  assign bcd_shift = {bcd_adj[BCDW-2:0], sh_reg[W-1]};
  assign bcd_pad   = BP'(bcd_shift);
  assign val_pad   = VP'(in_value);
  assign hex_ovf   = |(val_pad >> (4 * DIGITS));
  assign dec_ovf   = |(bcd_pad >> (4 * DIGITS));

  always_comb begin
    state_next    = state_reg;
    dig_next      = dig_reg;
    ovf_next      = ovf_reg;
    lzb_next      = lzb_reg;
    lzb_pend_next = lzb_pend_reg;
    bcd_next      = bcd_reg;
    sh_next       = sh_reg;
    cnt_next      = cnt_reg;
    in_ready      = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_dec) begin
            state_next    = CONV;
            bcd_next      = '0;
            sh_next       = in_value;
            cnt_next      = '0;
            lzb_pend_next = in_lzb;
          end else begin
            for (int i = 0; i < DIGITS; i++) dig_next[i] = val_pad[4*i +: 4];
            ovf_next = hex_ovf;
            lzb_next = in_lzb;
          end
        end
      end
      CONV: begin
        bcd_next = bcd_shift;
        sh_next  = sh_reg << 1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CW'(W - 1)) begin
          state_next = IDLE;
          for (int i = 0; i < DIGITS; i++) dig_next[i] = bcd_pad[4*i +: 4];
          ovf_next = dec_ovf;
          lzb_next = lzb_pend_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      for (int i = 0; i < DIGITS; i++) dig_reg[i] <= 4'd0;
      ovf_reg       <= 1'b0;
      lzb_reg       <= 1'b0;
      lzb_pend_reg  <= 1'b0;
      bcd_reg       <= '0;
      sh_reg        <= '0;
      cnt_reg       <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dig_reg      <= dig_next;
      ovf_reg      <= ovf_next;
      lzb_reg      <= lzb_next;
      lzb_pend_reg <= lzb_pend_next;
      bcd_reg      <= bcd_next;
      sh_reg       <= sh_next;
      cnt_reg      <= cnt_next;
      if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
        blink_cnt_reg <= '0;
        phase_reg     <= ~phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 8'h03;  4'h1: glyph = 8'h9F;  4'h2: glyph = 8'h25;  4'h3: glyph = 8'h0D;
      4'h4: glyph = 8'h99;  4'h5: glyph = 8'h49;  4'h6: glyph = 8'h41;  4'h7: glyph = 8'h1F;
      4'h8: glyph = 8'h01;  4'h9: glyph = 8'h09;  4'hA: glyph = 8'h11;  4'hB: glyph = 8'hC1;
      4'hC: glyph = 8'h63;  4'hD: glyph = 8'h85;  4'hE: glyph = 8'h61;  default: glyph = 8'h71;
    endcase
  endfunction

  // Digit 0 is never blanked; higher digits blank while everything from them upward is zero
  logic [DIGITS-1:0] blank;
  logic              zero_above;
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (dig_reg[i] == 4'd0);
      blank[i]   = lzb_reg & ~ovf_reg & zero_above;
    end
  end

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_out
      logic [7:0] seg_byte;
      always_comb begin
        if (ovf_reg)        seg_byte = 8'hFD;
        else if (blank[gi]) seg_byte = 8'hFF;
        else                seg_byte = glyph(dig_reg[gi]);
        if (dp_mask[gi])    seg_byte[0] = 1'b0;
        if (phase_reg && blink_mask[gi]) seg_byte = 8'hFF;
      end
      assign o_seg[8*gi +: 8] = seg_byte;
    end
  endgenerate

  assign o_ovf = ovf_reg;
endmodule
